// File: rtl/led_scroll_driver.sv
// Multiplexed seven-segment scroller: shows a DIGITS-wide window into a nibble buffer,
// advanced by debounced button presses or an auto-scroll timer.
module led_scroll_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned MSG_LEN      = 16,
    parameter int unsigned REFRESH_DIV  = 16,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned AUTO_PERIOD  = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       button,
    input  logic                       auto_en,
    input  logic                       msg_we,
    input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
    input  logic [3:0]                 msg_data,
    output logic [DIGITS-1:0]          an,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [$clog2(MSG_LEN)-1:0] pos
);
    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned SW = $clog2(REFRESH_DIV);
    localparam int unsigned DW = $clog2(DIGITS);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TW = $clog2(AUTO_PERIOD);

    logic [3:0]        buf_q [MSG_LEN];
    logic              sync1_q, sync2_q;
    logic              db_q, db_d;
    logic [CW-1:0]     db_cnt_q, db_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [AW-1:0]     pos_q, pos_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              btn_step, auto_step, step;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        hex7 = '1;
        case (v)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            4'hF: hex7 = 7'b0111000;
        endcase
    endfunction

    // Counter must already hold DEBOUNCE_CYC while still differing, so a change
    // needs DEBOUNCE_CYC+1 consecutive differing samples; the rising flip steps directly.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        btn_step = 1'b0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == CW'(DEBOUNCE_CYC)) begin
                db_d     = ~db_q;
                btn_step = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        auto_step = auto_en && (timer_q == TW'(AUTO_PERIOD - 1));
        step      = btn_step | auto_step;
        timer_d   = (!auto_en || step) ? '0 : timer_q + TW'(1);
        pos_d     = step ? pos_q + AW'(1) : pos_q;
    end

    // The window index is captured in the blanking cycle so a slot never mixes positions.
    always_comb begin
        slot_d  = (slot_q == SW'(REFRESH_DIV - 1)) ? '0 : slot_q + SW'(1);
        digit_d = digit_q;
        idx_d   = idx_q;
        if (slot_q == SW'(REFRESH_DIV - 1)) begin
            digit_d = (digit_q == '0) ? DW'(DIGITS - 1) : digit_q - DW'(1);
        end
        if (slot_q == '0) begin
            idx_d = pos_q + AW'(DIGITS - 1) - AW'(digit_q);
        end
    end

    always_comb begin
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (slot_q != '0) begin
            an_d  = ~(DIGITS'(1) << digit_q);
            seg_d = hex7(buf_q[idx_q]);
            dp_d  = (idx_q != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                buf_q[i] <= 4'(i % 16);
            end
        end else if (msg_we) begin
            buf_q[msg_addr] <= msg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            timer_q  <= '0;
            pos_q    <= '0;
            slot_q   <= '0;
            digit_q  <= DW'(DIGITS - 1);
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= '1;
            dp_q     <= 1'b1;
        end else begin
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign pos = pos_q;

endmodule
